fpu_ctrl: RTL and testbench

- Bus-side controller and sequencer for the FPU datapath core.
- Owns the CPU-visible register file (operands, operation, result, status) on the 8-bit Sol-1 peripheral bus.
- Launches one datapath operation per command write, waits for completion, latches the result, and raises cmd_end (IRQ) until the CPU acknowledges it.
- Sits between the CPU bus decode and the FPU datapath; the datapath itself contains no bus logic.

---
 rtl/fpu_ctrl_pkg.sv | 50 +++++
 rtl/fpu_ctrl_regfile.sv | 105 ++++++++++
 rtl/fpu_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fpu_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_ctrl_pkg.sv
// pa_fpu: shared types and constants for the FPU bus controller.
//   e_fpu_operation  - datapath operation codes (add/sub/mul/div)
//   e_fpu_ctrl_state - controller sequencer states
//   FPU_REG_*        - CPU-visible register addresses
//   ST_*             - STATUS register bit positions
//   FPU_QNAN         - quiet NaN returned when an operation is aborted
package pa_fpu;

  typedef enum logic [3:0] {
    op_add = 4'd0,
    op_sub = 4'd1,
    op_mul = 4'd2,
    op_div = 4'd3
  } e_fpu_operation;

  typedef enum logic [1:0] {
    ctrl_idle_st,
    ctrl_launch_st,
    ctrl_wait_st
  } e_fpu_ctrl_state;

  localparam logic [5:0] FPU_REG_A0     = 6'h00;
  localparam logic [5:0] FPU_REG_A1     = 6'h01;
  localparam logic [5:0] FPU_REG_A2     = 6'h02;
  localparam logic [5:0] FPU_REG_A3     = 6'h03;
  localparam logic [5:0] FPU_REG_B0     = 6'h04;
  localparam logic [5:0] FPU_REG_B1     = 6'h05;
  localparam logic [5:0] FPU_REG_B2     = 6'h06;
  localparam logic [5:0] FPU_REG_B3     = 6'h07;
  localparam logic [5:0] FPU_REG_OP     = 6'h08;
  localparam logic [5:0] FPU_REG_RES0   = 6'h09;
  localparam logic [5:0] FPU_REG_RES1   = 6'h0A;
  localparam logic [5:0] FPU_REG_RES2   = 6'h0B;
  localparam logic [5:0] FPU_REG_RES3   = 6'h0C;
  localparam logic [5:0] FPU_REG_STATUS = 6'h0D;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_ERR_BUSY = 2;
  localparam int ST_TIMEOUT  = 3;
  localparam int ST_BAD_OP   = 4;

  localparam logic [31:0] FPU_QNAN = 32'h7FC00000;

  // Only add/sub/mul/div are implemented by the datapath.
  function automatic logic op_is_valid(input logic [3:0] code);
    return code <= 4'd3;
  endfunction

endpackage

// File: rtl/fpu_ctrl_regfile.sv
// fpu_ctrl_regfile: CPU-visible register file of the FPU controller.
//   clk, arst          - clock, synchronous active-high reset
//   databus_in, addr   - CPU write data and register address
//   cs, rd, wr         - active-low chip select / read / write strobes
//   busy               - controller busy; all writes are rejected while set
//   result_we/result_in- result load from the sequencer
//   status             - STATUS byte assembled by the sequencer
//   databus_out        - read data, 'z when not being read
//   wr_edge            - one-cycle pulse on the first cycle of a write strobe
//   a, b, op           - operand and operation registers
module fpu_ctrl_regfile
  import pa_fpu::*;
(
  input  logic        clk,
  input  logic        arst,
  input  logic [7:0]  databus_in,
  input  logic [5:0]  addr,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic        busy,
  input  logic        result_we,
  input  logic [31:0] result_in,
  input  logic [7:0]  status,
  output logic [7:0]  databus_out,
  output logic        wr_edge,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  op
);

  logic        wr_act;
  logic        wr_act_q;
  logic [31:0] a_d, a_q, b_d, b_q, result_d, result_q;
  logic [3:0]  op_d, op_q;
  logic [7:0]  rd_data;

  assign wr_act  = !cs && !wr;
  // Only the leading edge of a strobe writes, however long it is held.
  assign wr_edge = wr_act && !wr_act_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_we ? result_in : result_q;
    if (wr_edge && !busy) begin
      case (addr)
        FPU_REG_A0: a_d[7:0]   = databus_in;
        FPU_REG_A1: a_d[15:8]  = databus_in;
        FPU_REG_A2: a_d[23:16] = databus_in;
        FPU_REG_A3: a_d[31:24] = databus_in;
        FPU_REG_B0: b_d[7:0]   = databus_in;
        FPU_REG_B1: b_d[15:8]  = databus_in;
        FPU_REG_B2: b_d[23:16] = databus_in;
        FPU_REG_B3: b_d[31:24] = databus_in;
        FPU_REG_OP: op_d       = databus_in[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      wr_act_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= op_add;
      result_q <= '0;
    end else begin
      wr_act_q <= wr_act;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      FPU_REG_A0:     rd_data = a_q[7:0];
      FPU_REG_A1:     rd_data = a_q[15:8];
      FPU_REG_A2:     rd_data = a_q[23:16];
      FPU_REG_A3:     rd_data = a_q[31:24];
      FPU_REG_B0:     rd_data = b_q[7:0];
      FPU_REG_B1:     rd_data = b_q[15:8];
      FPU_REG_B2:     rd_data = b_q[23:16];
      FPU_REG_B3:     rd_data = b_q[31:24];
      FPU_REG_OP:     rd_data = {4'h0, op_q};
      FPU_REG_RES0:   rd_data = result_q[7:0];
      FPU_REG_RES1:   rd_data = result_q[15:8];
      FPU_REG_RES2:   rd_data = result_q[23:16];
      FPU_REG_RES3:   rd_data = result_q[31:24];
      FPU_REG_STATUS: rd_data = status;
      default:        rd_data = 8'h00;
    endcase
  end

  assign databus_out = (!cs && !rd) ? rd_data : 8'hzz;
  assign a  = a_q;
  assign b  = b_q;
  assign op = op_q;

endmodule

// File: rtl/fpu_ctrl.sv
// fpu_ctrl: bus-side controller and sequencer for the FPU datapath.
//   clk, arst               - clock, synchronous active-high reset
//   databus_in/out, addr,
//   cs, rd, wr              - 8-bit peripheral bus (strobes active-low)
//   end_ack                 - CPU acknowledge, clears cmd_end and done
//   cmd_end                 - completion IRQ level
//   busy                    - operation in progress
//   dp_start, dp_op,
//   dp_a, dp_b              - launch pulse and operands to the datapath
//   dp_done, dp_result      - completion pulse and result from the datapath
// Optional watchdog: define FPU_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles with a qNaN result and STATUS.timeout set.
module fpu_ctrl
  import pa_fpu::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [7:0]  databus_in,
  output logic [7:0]  databus_out,
  input  logic [5:0]  addr,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic        end_ack,
  output logic        cmd_end,
  output logic        busy,
  output logic        dp_start,
  output logic [3:0]  dp_op,
  output logic [31:0] dp_a,
  output logic [31:0] dp_b,
  input  logic        dp_done,
  input  logic [31:0] dp_result
);

  e_fpu_ctrl_state state_d, state_q;
  logic busy_d, busy_q, cmd_end_d, cmd_end_q, done_d, done_q;
  logic err_busy_d, err_busy_q, timeout_d, timeout_q, bad_op_d, bad_op_q;
  logic dp_start_d, dp_start_q;
  logic wr_edge, cmd_write, result_we;
  logic [31:0] result_in;
  logic [7:0]  status;

`ifdef FPU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0) ^ (CNT_W > 0);
`endif

  assign status = {3'b000, bad_op_q, timeout_q, err_busy_q, done_q, busy_q};

  fpu_ctrl_regfile u_regfile (
    .clk        (clk),
    .arst       (arst),
    .databus_in (databus_in),
    .addr       (addr),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .busy       (busy_q),
    .result_we  (result_we),
    .result_in  (result_in),
    .status     (status),
    .databus_out(databus_out),
    .wr_edge    (wr_edge),
    .a          (dp_a),
    .b          (dp_b),
    .op         (dp_op)
  );

  assign cmd_write = wr_edge && (addr == FPU_REG_OP) && !busy_q;

  // Acknowledge is applied first so a completion later in this block wins.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    cmd_end_d  = cmd_end_q;
    done_d     = done_q;
    err_busy_d = err_busy_q;
    timeout_d  = timeout_q;
    bad_op_d   = bad_op_q;
    dp_start_d = 1'b0;
    result_we  = 1'b0;
    result_in  = dp_result;
`ifdef FPU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    if (end_ack && cmd_end_q) begin
      cmd_end_d = 1'b0;
      done_d    = 1'b0;
    end

    if (wr_edge && busy_q) err_busy_d = 1'b1;

    case (state_q)
      ctrl_idle_st: begin
        if (cmd_write) begin
          if (op_is_valid(databus_in[3:0])) begin
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            err_busy_d = 1'b0;
            bad_op_d   = 1'b0;
            cmd_end_d  = 1'b0;
            busy_d     = 1'b1;
            dp_start_d = 1'b1;
            state_d    = ctrl_launch_st;
          end else begin
            bad_op_d  = 1'b1;
            cmd_end_d = 1'b1;
            done_d    = 1'b1;
          end
        end
      end
      ctrl_launch_st: begin
`ifdef FPU_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ctrl_wait_st;
      end
      ctrl_wait_st: begin
        if (dp_done) begin
          result_we = 1'b1;
          done_d    = 1'b1;
          cmd_end_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ctrl_idle_st;
        end
`ifdef FPU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          result_we = 1'b1;
          result_in = FPU_QNAN;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          cmd_end_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = ctrl_idle_st;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ctrl_idle_st;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_q    <= ctrl_idle_st;
      busy_q     <= 1'b0;
      cmd_end_q  <= 1'b0;
      done_q     <= 1'b0;
      err_busy_q <= 1'b0;
      timeout_q  <= 1'b0;
      bad_op_q   <= 1'b0;
      dp_start_q <= 1'b0;
`ifdef FPU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      cmd_end_q  <= cmd_end_d;
      done_q     <= done_d;
      err_busy_q <= err_busy_d;
      timeout_q  <= timeout_d;
      bad_op_q   <= bad_op_d;
      dp_start_q <= dp_start_d;
`ifdef FPU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign cmd_end  = cmd_end_q;
  assign busy     = busy_q;
  assign dp_start = dp_start_q;

endmodule

// File: tb/tb_fpu_ctrl.sv
// tb_fpu_ctrl: directed, table-driven bench for fpu_ctrl.
// Register access vectors come from a table; completion, busy rejection,
// ack race, invalid op, reset and watchdog behaviour use short sequences.
module tb_fpu_ctrl;

  logic        clk = 1'b0;
  logic        arst;
  logic [7:0]  databus_in;
  logic [7:0]  databus_out;
  logic [5:0]  addr;
  logic        cs, rd, wr;
  logic        end_ack;
  logic        cmd_end, busy, dp_start;
  logic [3:0]  dp_op;
  logic [31:0] dp_a, dp_b;
  logic        dp_done;
  logic [31:0] dp_result;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fpu_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
    .clk        (clk),
    .arst       (arst),
    .databus_in (databus_in),
    .databus_out(databus_out),
    .addr       (addr),
    .cs         (cs),
    .rd         (rd),
    .wr         (wr),
    .end_ack    (end_ack),
    .cmd_end    (cmd_end),
    .busy       (busy),
    .dp_start   (dp_start),
    .dp_op      (dp_op),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_done    (dp_done),
    .dp_result  (dp_result)
  );

  typedef struct {
    bit         is_wr;
    logic [5:0] a;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Write strobe held for one full cycle; returns at the negedge after the write edge.
  task automatic busWrite(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
    @(negedge clk);
    cs = 1'b1; wr = 1'b1;
  endtask

  task automatic busRead(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; cs = 1'b0; rd = 1'b0;
    #1 d = databus_out;
    cs = 1'b1; rd = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [7:0] d;
    if (v.is_wr) busWrite(v.a, v.data);
    else begin
      busRead(v.a, d);
      checkOutput($sformatf("vec%0d_rd_%h", idx, v.a), {24'h0, d}, {24'h0, v.exp});
    end
  endtask

  task automatic readCheck(input string name, input logic [5:0] a, input logic [7:0] exp);
    logic [7:0] d;
    busRead(a, d);
    checkOutput(name, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic pulseAck();
    @(negedge clk);
    end_ack = 1'b1;
    @(negedge clk);
    end_ack = 1'b0;
  endtask

  initial begin
    int busyCycles;
    int starts;
    arst = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = '0; databus_in = '0;
    end_ack = 1'b0; dp_done = 1'b0; dp_result = '0;
    repeat (3) @(negedge clk);
    arst = 1'b0;

    // Reset state
    checkOutput("rst_cmd_end", {31'h0, cmd_end}, 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_dp_start", {31'h0, dp_start}, 32'h0);
    checkOutput("rst_dp_op", {28'h0, dp_op}, 32'h0);
    checkOutput("rst_dp_a", dp_a, 32'h0);
    checkOutput("rst_dp_b", dp_b, 32'h0);

    // Register access table
    vecs.push_back('{1'b0, 6'h0D, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 6'h08, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 6'h05, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 6'h00, 8'h11, 8'h00});
    vecs.push_back('{1'b1, 6'h01, 8'h22, 8'h00});
    vecs.push_back('{1'b1, 6'h02, 8'h33, 8'h00});
    vecs.push_back('{1'b1, 6'h03, 8'h44, 8'h00});
    vecs.push_back('{1'b0, 6'h00, 8'h00, 8'h11});
    vecs.push_back('{1'b0, 6'h03, 8'h00, 8'h44});
    vecs.push_back('{1'b1, 6'h04, 8'h55, 8'h00});
    vecs.push_back('{1'b1, 6'h07, 8'h66, 8'h00});
    vecs.push_back('{1'b0, 6'h04, 8'h00, 8'h55});
    vecs.push_back('{1'b0, 6'h07, 8'h00, 8'h66});
    vecs.push_back('{1'b1, 6'h0E, 8'hAA, 8'h00});
    vecs.push_back('{1'b0, 6'h0E, 8'h00, 8'h00});
    vecs.push_back('{1'b1, 6'h09, 8'hAA, 8'h00});
    vecs.push_back('{1'b0, 6'h09, 8'h00, 8'h00});
    vecs.push_back('{1'b0, 6'h3F, 8'h00, 8'h00});
    foreach (vecs[i]) applyStimulus(vecs[i], i);
    checkOutput("tbl_dp_a", dp_a, 32'h44332211);
    checkOutput("tbl_dp_b", dp_b, 32'h66000055);
    checkOutput("tbl_no_launch", {31'h0, busy}, 32'h0);

    // 1. Add 1.0 + 2.0, completion on the 5th WAIT cycle
    busWrite(6'h00, 8'h00); busWrite(6'h01, 8'h00);
    busWrite(6'h02, 8'h80); busWrite(6'h03, 8'h3F);
    busWrite(6'h04, 8'h00); busWrite(6'h05, 8'h00);
    busWrite(6'h06, 8'h00); busWrite(6'h07, 8'h40);
    busWrite(6'h08, 8'h00);
    checkOutput("add_dp_a", dp_a, 32'h3F800000);
    checkOutput("add_dp_b", dp_b, 32'h40000000);
    checkOutput("add_dp_op", {28'h0, dp_op}, 32'h0);
    busyCycles = 0; starts = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy) busyCycles++;
      if (dp_start) starts++;
      if (i == 5) begin dp_done = 1'b1; dp_result = 32'h40400000; end
      if (i == 4) checkOutput("add_cmd_end_pre", {31'h0, cmd_end}, 32'h0);
      @(negedge clk);
      dp_done = 1'b0;
    end
    checkOutput("add_start_pulses", starts, 32'd1);
    checkOutput("add_busy_cycles", busyCycles, 32'd6);
    checkOutput("add_cmd_end", {31'h0, cmd_end}, 32'h1);
    checkOutput("add_busy_after", {31'h0, busy}, 32'h0);
    readCheck("add_res0", 6'h09, 8'h00);
    readCheck("add_res1", 6'h0A, 8'h00);
    readCheck("add_res2", 6'h0B, 8'h40);
    readCheck("add_res3", 6'h0C, 8'h40);
    readCheck("add_status", 6'h0D, 8'h02);
    pulseAck();
    checkOutput("add_ack", {31'h0, cmd_end}, 32'h0);

    // 2. Busy rejection
    busWrite(6'h08, 8'h01);
    busWrite(6'h00, 8'hFF);
    checkOutput("rej_dp_a", dp_a, 32'h3F800000);
    readCheck("rej_status", 6'h0D, 8'h05);
    readCheck("rej_a0", 6'h00, 8'h00);
    @(negedge clk);
    dp_done = 1'b1; dp_result = 32'hC0000000;
    @(negedge clk);
    dp_done = 1'b0;
    checkOutput("rej_cmd_end", {31'h0, cmd_end}, 32'h1);
    readCheck("rej_status_done", 6'h0D, 8'h06);

    // 3. Ack race on the completion edge; valid OP clears err_busy
    busWrite(6'h08, 8'h02);
    checkOutput("race_cmd_end_clr", {31'h0, cmd_end}, 32'h0);
    readCheck("race_status_busy", 6'h0D, 8'h01);
    dp_done = 1'b1; end_ack = 1'b1; dp_result = 32'hC1000000;
    @(negedge clk);
    dp_done = 1'b0; end_ack = 1'b0;
    checkOutput("race_set_wins", {31'h0, cmd_end}, 32'h1);
    pulseAck();
    checkOutput("race_ack", {31'h0, cmd_end}, 32'h0);
    readCheck("race_status", 6'h0D, 8'h00);
    pulseAck();
    checkOutput("race_idle_ack", {31'h0, cmd_end}, 32'h0);

    // 4. Invalid op
    busWrite(6'h08, 8'h07);
    checkOutput("bad_dp_start", {31'h0, dp_start}, 32'h0);
    checkOutput("bad_busy", {31'h0, busy}, 32'h0);
    checkOutput("bad_cmd_end", {31'h0, cmd_end}, 32'h1);
    checkOutput("bad_dp_op", {28'h0, dp_op}, 32'h7);
    readCheck("bad_status", 6'h0D, 8'h12);
    readCheck("bad_res3", 6'h0C, 8'hC1);
    pulseAck();

    // 5. Reset mid-operation; later dp_done ignored
    busWrite(6'h08, 8'h00);
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    checkOutput("mid_rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("mid_rst_cmd_end", {31'h0, cmd_end}, 32'h0);
    checkOutput("mid_rst_dp_a", dp_a, 32'h0);
    checkOutput("mid_rst_dp_b", dp_b, 32'h0);
    dp_done = 1'b1; dp_result = 32'hDEADBEEF;
    @(negedge clk);
    dp_done = 1'b0;
    checkOutput("mid_rst_late_done", {31'h0, cmd_end}, 32'h0);
    readCheck("mid_rst_res3", 6'h0C, 8'h00);
    readCheck("mid_rst_status", 6'h0D, 8'h00);

    // 6. Watchdog
    busWrite(6'h08, 8'h03);
`ifdef FPU_TIMEOUT_EN
    repeat (8) @(negedge clk);
    checkOutput("to_before", {31'h0, cmd_end}, 32'h0);
    @(negedge clk);
    checkOutput("to_cmd_end", {31'h0, cmd_end}, 32'h1);
    checkOutput("to_busy", {31'h0, busy}, 32'h0);
    readCheck("to_res3", 6'h0C, 8'h7F);
    readCheck("to_res2", 6'h0B, 8'hC0);
    readCheck("to_status", 6'h0D, 8'h0A);
`else
    repeat (30) @(negedge clk);
    checkOutput("nto_cmd_end", {31'h0, cmd_end}, 32'h0);
    checkOutput("nto_busy", {31'h0, busy}, 32'h1);
    readCheck("nto_status", 6'h0D, 8'h01);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
